game_timer_lives: RTL and testbench

//  Status datapath that answers the one-hot game FSM. It consumes the FSM's

---
 rtl/game_timer_lives.sv | 80 ++++++++
 tb/tb_game_timer_lives.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/game_timer_lives.sv
// Status datapath for the one-hot game FSM: death-delay counter (TC), lives
// bookkeeping (LIVES/LIFE), survival score and the death-flash bit.
module game_timer_lives #(
    parameter int NUM_LIVES  = 3,
    parameter int LIVES_W    = 2,
    parameter int DEAD_TICKS = 8,
    parameter int CNT_W      = 3,
    parameter int SCORE_W    = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               TICK,
    input  logic               LOADLIFE,
    input  logic               RELOAD,
    input  logic               RESET,
    input  logic               DEAD,
    input  logic               GAME,
    input  logic               HALT,
    output logic               TC,
    output logic               LIFE,
    output logic [LIVES_W-1:0] LIVES,
    output logic [SCORE_W-1:0] SCORE,
    output logic               FLASH
);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEAD_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    logic [CNT_W-1:0] cnt;

    // Any drop of DEAD restarts the delay, so TC only follows an unbroken run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            TC    <= 1'b0;
            FLASH <= 1'b0;
        end else if (!DEAD) begin
            cnt   <= '0;
            TC    <= 1'b0;
            FLASH <= 1'b0;
        end else if (TICK) begin
            FLASH <= ~FLASH;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                TC  <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
                TC  <= 1'b0;
            end
        end else begin
            TC <= 1'b0;
        end
    end

    // The last life is never spent here; the FSM ends the game via LIFE instead.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LIVES <= LIVES_INIT;
        end else if (LOADLIFE) begin
            LIVES <= LIVES_INIT;
        end else if (RELOAD && (LIVES > LIVES_ONE)) begin
            LIVES <= LIVES - LIVES_ONE;
        end
    end

    assign LIFE = (LIVES == LIVES_ONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            SCORE <= '0;
        end else if (RESET || LOADLIFE) begin
            SCORE <= '0;
        end else if (TICK && GAME && !HALT && (SCORE != SCORE_MAX)) begin
            SCORE <= SCORE + SCORE_W'(1);
        end
    end

endmodule

// File: tb/tb_game_timer_lives.sv
// Directed self-checking bench for game_timer_lives with hand-computed values.
module tb_game_timer_lives;

    logic       clk = 1'b0;
    logic       rst, tick, loadLife, reload, resetCmd, dead, game, halt;
    logic       tc, life, flash;
    logic [1:0] lives;
    logic [7:0] score;

    int total = 0;
    int bad = 0;
    int tcCount = 0;
    logic tcAfterTick;

    game_timer_lives dut (
        .CLK(clk), .RST(rst), .TICK(tick), .LOADLIFE(loadLife),
        .RELOAD(reload), .RESET(resetCmd), .DEAD(dead), .GAME(game),
        .HALT(halt), .TC(tc), .LIFE(life), .LIVES(lives), .SCORE(score),
        .FLASH(flash)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; outputs are sampled 1ns past the edge.
    task automatic applyStimulus(input logic r, input logic t, input logic ll,
                                 input logic rl, input logic rc, input logic d,
                                 input logic g, input logic h);
        rst = r; tick = t; loadLife = ll; reload = rl;
        resetCmd = rc; dead = d; game = g; halt = h;
        @(posedge clk);
        #1;
        if (tc) tcCount++;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One TICK while dead followed by three idle dead cycles.
    task automatic deadTickPeriod();
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
        tcAfterTick = tc;
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        #2;
        // 1: reset state
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_lives", lives, 3);
        checkOutput("rst_life", life, 0);
        checkOutput("rst_tc", tc, 0);
        checkOutput("rst_score", score, 0);
        checkOutput("rst_flash", flash, 0);

        // 2: continuous dead interval
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        tcCount = 0;
        deadTickPeriod();
        checkOutput("flash_after1", flash, 1);
        repeat (6) deadTickPeriod();
        checkOutput("tc_none_7ticks", tcCount, 0);
        checkOutput("flash_after7", flash, 1);
        deadTickPeriod();
        checkOutput("tc_after8", tcAfterTick, 1);
        checkOutput("tc_one_cycle", tcCount, 1);
        checkOutput("flash_after8", flash, 0);
        repeat (7) deadTickPeriod();
        checkOutput("tc_none_15ticks", tcCount, 1);
        deadTickPeriod();
        checkOutput("tc_after16", tcAfterTick, 1);
        checkOutput("tc_two_pulses", tcCount, 2);

        // 3: a DEAD drop restarts the delay
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tcCount = 0;
        repeat (5) deadTickPeriod();
        checkOutput("flash_after5", flash, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flash_drop", flash, 0);
        repeat (7) deadTickPeriod();
        checkOutput("tc_restart_none", tcCount, 0);
        deadTickPeriod();
        checkOutput("tc_restart_8", tcAfterTick, 1);
        checkOutput("tc_restart_count", tcCount, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // 4: lives
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("lives_2", lives, 2);
        checkOutput("life_at2", life, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("lives_reset_cmd", lives, 2);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("lives_1", lives, 1);
        checkOutput("life_at1", life, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("lives_no_wrap", lives, 1);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("lives_load_wins", lives, 3);
        checkOutput("life_reloaded", life, 0);

        // 5: score
        repeat (10) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        end
        checkOutput("score_10", score, 10);
        repeat (290) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        end
        checkOutput("score_sat", score, 255);
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 1, 1);
        checkOutput("score_halt_sat", score, 255);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
        checkOutput("score_reset", score, 0);
        repeat (5) applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("score_5", score, 5);
        repeat (4) applyStimulus(0, 1, 0, 0, 0, 0, 1, 1);
        checkOutput("score_halt", score, 5);
        repeat (4) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("score_nogame", score, 5);
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 0);
        checkOutput("score_reset_tick", score, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0);
        checkOutput("score_loadlife", score, 0);

        // 6: RST on the 8th TICK cancels the pending TC
        repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("pre_rst_lives", lives, 2);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        tcCount = 0;
        repeat (7) deadTickPeriod();
        checkOutput("pre_rst_flash", flash, 1);
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
        checkOutput("rst8_tc", tc, 0);
        checkOutput("rst8_lives", lives, 3);
        checkOutput("rst8_life", life, 0);
        checkOutput("rst8_score", score, 0);
        checkOutput("rst8_flash", flash, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("rst8_no_tc", tcCount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
